instr_fetch: RTL and testbench

Fetch stage directly downstream of the `PC` register. It takes the current PC value, issues one word read at a time to instruction memory over a request/grant/response handshake, and presents the fetched instruction and its PC to decode with a valid/ready handshake. It drives the PC register's enable, so the PC advances once per granted fetch. On a branch or jump flush it discards any in-flight or buffered instruction.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding buffer used when decode stalls on a returning fetch.
module fetch_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, registered decode output, flush handling.
// Optional FETCH_ALIGN_CHECK_EN blocks misaligned fetches and raises a sticky misalign_err.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP  = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pc_in,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output fetch_state_t      fsm_state
);

  // Handshakes: imem transfer when imem_req && imem_gnt, one rvalid per grant;
  // decode transfer when id_valid && id_ready, id_* held stable while stalled.

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] req_pc;
  logic              misaligned;
  logic              grant;
  logic              out_free;
  logic              load_out;
  logic              load_skid;
  logic              drain_skid;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_instr;
  logic [DATA_W-1:0] skid_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |(pc_in[1:0] & ~ADDR_ALIGN_MASK[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign imem_addr = {pc_in[DATA_W-1:2], 2'b00};
  assign out_free  = !id_valid || id_ready;
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    pc_en      = flush;
    grant      = 1'b0;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    drain_skid = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = !flush && out_free && !misaligned;
        if (imem_req && imem_gnt) begin
          grant   = 1'b1;
          pc_en   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          if (out_free) begin
            load_out = 1'b1;
            state_d  = REQ;
          end else begin
            load_skid = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = REQ;
        end else if (id_ready) begin
          drain_skid = 1'b1;
          state_d    = REQ;
        end
      end
      // A flush here keeps waiting for the one discarded response still owed.
      DROP: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     req_pc <= '0;
    else if (grant) req_pc <= pc_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end else if (load_out) begin
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_pc    <= req_pc;
    end else if (drain_skid) begin
      id_valid <= 1'b1;
      id_instr <= skid_instr;
      id_pc    <= skid_pc;
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

  fetch_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_skid),
    .drain    (drain_skid),
    .clear    (flush),
    .instr_in (imem_rdata),
    .pc_in    (req_pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             misalign_err <= 1'b0;
    else if (flush)                         misalign_err <= 1'b0;
    else if (state_q == REQ && misaligned)  misalign_err <= 1'b1;
  end
`endif

  // Skid occupancy mirrors HOLD; kept as a consistency check on the FSM.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == HOLD) assert (skid_valid);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed table, hand sequences, randomized run vs. a queue model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] NOPV = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic MIS_REQ = 1'b0;
`else
  localparam logic MIS_REQ = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pc_in;
  logic         pc_en;
  logic         flush;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         id_valid;
  logic         id_ready;
  logic [31:0]  id_instr;
  logic [31:0]  id_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         misalign_err;
`endif
  fetch_state_t fsm_state;

  always #5 clk = ~clk;

  instr_fetch #(.DATA_W(32), .NOP(NOPV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .fsm_state   (fsm_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_st(input string name, input fetch_state_t exp);
    chk(name, 32'(fsm_state), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic hold_reset(input logic [31:0] pc);
    rst_n = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; id_ready = 1'b1; pc_in = pc;
    repeat (2) tick();
    smp();
  endtask

  // Directed vectors applied in REQ with an empty output register.
  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_pc_en;
  } vec_t;
  vec_t vecs[8];

  // Reference model state for the randomized run.
  logic [63:0] exp_q[$];
  bit          outstanding;
  bit          discard;
  int          lat;
  logic [31:0] out_pc;
  bit          prev_stall;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  int          nxfer;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic rand_cycle(input bit allow_flush, input bit allow_gnt);
    logic        grant;
    logic        s_pc_en;
    logic        s_flush;
    logic [63:0] e;
    id_ready = allow_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_gnt = allow_gnt && ($urandom_range(0, 2) != 0);
    flush    = allow_flush && !discard && ($urandom_range(0, 19) == 0);
    if (outstanding && lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(out_pc);
    end else begin
      if (outstanding) lat--;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    smp();
    grant = imem_req && imem_gnt;
    if (imem_req) chk("r_addr", imem_addr, pc_in & 32'hFFFF_FFFC);
    chk1("r_pc_en", pc_en, flush || grant);
    if (outstanding && !imem_rvalid) chk1("r_req_while_busy", imem_req, 1'b0);
    chk1("r_valid", id_valid, exp_q.size() != 0);
    if (prev_stall) begin
      chk("r_stall_instr", id_instr, prev_instr);
      chk("r_stall_pc", id_pc, prev_pc);
    end
    if (id_valid && id_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("r_pc", id_pc, e[63:32]);
      chk("r_instr", id_instr, e[31:0]);
      nxfer++;
    end
    if (imem_rvalid) begin
      outstanding = 1'b0;
      if (!discard && !flush) exp_q.push_back({out_pc, mem_word(out_pc)});
      discard = 1'b0;
    end
    if (flush) begin
      exp_q.delete();
      if (outstanding) discard = 1'b1;
    end
    if (grant) begin
      outstanding = 1'b1;
      out_pc      = pc_in;
      lat         = $urandom_range(0, 3);
    end
    prev_stall = id_valid && !id_ready && !flush;
    prev_instr = id_instr;
    prev_pc    = id_pc;
    s_pc_en    = pc_en;
    s_flush    = flush;
    tick();
    if (s_pc_en) pc_in = s_flush ? ($urandom & 32'hFFFF_FFFC) : pc_in + 32'd4;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0080, 1'b0, 1'b0, 1'b1,    32'h0000_0080, 1'b0};
    vecs[1] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1,    32'hFFFF_FFFC, 1'b0};
    vecs[2] = '{32'h0000_0087, 1'b0, 1'b0, MIS_REQ, 32'h0000_0084, 1'b0};
    vecs[3] = '{32'h0000_0104, 1'b1, 1'b1, 1'b0,    32'h0000_0104, 1'b1};
    vecs[4] = '{32'h0000_0010, 1'b1, 1'b0, 1'b0,    32'h0000_0010, 1'b1};
    vecs[5] = '{32'h0000_003A, 1'b0, 1'b0, MIS_REQ, 32'h0000_0038, 1'b0};
    vecs[6] = '{32'h0000_0200, 1'b1, 1'b0, 1'b0,    32'h0000_0200, 1'b1};
    vecs[7] = '{32'h0000_0044, 1'b0, 1'b1, 1'b1,    32'h0000_0044, 1'b1};

    // Reset values
    hold_reset(32'h0000_0080);
    chk_st("rst_state", IDLE);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_valid", id_valid, 1'b0);
    chk("rst_instr", id_instr, NOPV);
    chk("rst_pc", id_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk1("rst_misalign", misalign_err, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    // Table-driven combinational checks in REQ
    for (int i = 0; i < 8; i++) begin
      pc_in = vecs[i].pc; flush = vecs[i].fl; imem_gnt = vecs[i].gnt;
      smp();
      chk_st($sformatf("tbl%0d_state", i), REQ);
      chk1($sformatf("tbl%0d_req", i), imem_req, vecs[i].exp_req);
      chk($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk1($sformatf("tbl%0d_pc_en", i), pc_en, vecs[i].exp_pc_en);
      tick();
    end
    flush = 1'b0; imem_gnt = 1'b0;
    smp();
    chk_st("tbl_end_wait", WAIT);

    // Reset and first fetch
    hold_reset(32'h0000_0080);
    rst_n = 1'b1;
    tick();
    imem_gnt = 1'b1;
    smp();
    chk1("a_req", imem_req, 1'b1);
    chk("a_addr", imem_addr, 32'h0000_0080);
    chk1("a_pc_en", pc_en, 1'b1);
    tick();
    pc_in = 32'h84; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005; id_ready = 1'b0;
    smp();
    chk_st("a_state_wait", WAIT);
    chk1("a_pc_en_once", pc_en, 1'b0);
    tick();
    imem_rvalid = 1'b0;
    smp();
    chk1("a_valid", id_valid, 1'b1);
    chk("a_instr", id_instr, 32'h2008_0005);
    chk("a_pc", id_pc, 32'h0000_0080);

    // Back-pressure: no request and stable outputs while decode stalls
    for (int i = 0; i < 3; i++) begin
      tick();
      smp();
      chk1("b_no_req", imem_req, 1'b0);
      chk("b_hold_instr", id_instr, 32'h2008_0005);
      chk("b_hold_pc", id_pc, 32'h0000_0080);
    end
    tick();
    id_ready = 1'b1; imem_gnt = 1'b1;
    smp();
    chk1("b_req", imem_req, 1'b1);
    chk("b_addr", imem_addr, 32'h0000_0084);
    tick();
    pc_in = 32'h88; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222; id_ready = 1'b0;
    smp();
    chk1("b_drained", id_valid, 1'b0);
    tick();
    imem_rvalid = 1'b0;
    smp();
    chk1("b_valid2", id_valid, 1'b1);
    chk("b_instr2", id_instr, 32'h1111_2222);
    chk("b_pc2", id_pc, 32'h0000_0084);

    // Grant stall
    tick();
    id_ready = 1'b1; imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk1("c_req", imem_req, 1'b1);
      chk("c_addr", imem_addr, 32'h0000_0088);
      chk1("c_pc_en", pc_en, 1'b0);
      tick();
    end
    imem_gnt = 1'b1;
    smp();
    chk1("c_pc_en_gnt", pc_en, 1'b1);

    // Flush in WAIT, response arrives later and is dropped
    tick();
    pc_in = 32'h8C; imem_gnt = 1'b0; flush = 1'b1;
    smp();
    chk_st("d_state_wait", WAIT);
    chk1("d_pc_en_flush", pc_en, 1'b1);
    tick();
    flush = 1'b0; pc_in = 32'h100;
    smp();
    chk_st("d_state_drop", DROP);
    chk1("d_valid0", id_valid, 1'b0);
    tick();
    smp();
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    smp();
    chk_st("d_still_drop", DROP);
    chk1("d_no_req", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b0;
    smp();
    chk_st("d_back_req", REQ);
    chk1("d_valid1", id_valid, 1'b0);
    chk("d_instr_nop", id_instr, NOPV);
    chk1("d_req", imem_req, 1'b1);
    chk("d_addr", imem_addr, 32'h0000_0100);

    // Flush coinciding with rvalid
    tick();
    imem_gnt = 1'b1;
    smp();
    chk1("e_pc_en", pc_en, 1'b1);
    tick();
    imem_gnt = 1'b0; pc_in = 32'h104; imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA; flush = 1'b1;
    smp();
    chk_st("e_state_wait", WAIT);
    tick();
    imem_rvalid = 1'b0; flush = 1'b0; pc_in = 32'h200;
    smp();
    chk_st("e_state_req", REQ);
    chk1("e_valid", id_valid, 1'b0);
    chk("e_instr_nop", id_instr, NOPV);
    chk("e_addr", imem_addr, 32'h0000_0200);

    // Flush while a stalled instruction is presented
    tick();
    imem_gnt = 1'b1; id_ready = 1'b0;
    smp();
    tick();
    imem_gnt = 1'b0; pc_in = 32'h204; imem_rvalid = 1'b1; imem_rdata = 32'h7777_0001;
    smp();
    tick();
    imem_rvalid = 1'b0;
    smp();
    chk1("e2_valid", id_valid, 1'b1);
    chk("e2_instr", id_instr, 32'h7777_0001);
    chk("e2_pc", id_pc, 32'h0000_0200);
    tick();
    flush = 1'b1;
    smp();
    tick();
    flush = 1'b0; pc_in = 32'h300; id_ready = 1'b1;
    smp();
    chk1("e2_flushed", id_valid, 1'b0);
    chk("e2_nop", id_instr, NOPV);
    chk_st("e2_state", REQ);

    // Misalignment
`ifdef FETCH_ALIGN_CHECK_EN
    tick();
    pc_in = 32'h82;
    smp();
    chk1("f_no_req", imem_req, 1'b0);
    chk1("f_no_pc_en", pc_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      smp();
      chk1("f_err", misalign_err, 1'b1);
      chk_st("f_state", REQ);
    end
    tick();
    flush = 1'b1;
    smp();
    tick();
    flush = 1'b0; pc_in = 32'h300;
    smp();
    chk1("f_err_clr", misalign_err, 1'b0);
    chk1("f_req", imem_req, 1'b1);
`else
    tick();
    pc_in = 32'h82;
    smp();
    chk1("f_req", imem_req, 1'b1);
    chk("f_addr", imem_addr, 32'h0000_0080);
`endif

    // Randomized run against the queue model
    hold_reset(32'h0000_1000);
    rst_n = 1'b1;
    tick();
    outstanding = 1'b0; discard = 1'b0; lat = 0; out_pc = '0;
    prev_stall = 1'b0; prev_instr = '0; prev_pc = '0; nxfer = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) rand_cycle(1'b1, 1'b1);
    for (int cyc = 0; cyc < 12; cyc++) rand_cycle(1'b0, 1'b0);
    chk("r_drained", 32'(exp_q.size()), 32'd0);
    chk1("r_no_outstanding", outstanding, 1'b0);
    chk1("r_progress", nxfer > 300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
